// File: rtl/stu_spec_validator.sv
// Speculative-task validator: tracks one Level-2 speculative task and decides commit or squash.
// Decision pulses are registered, two cycles after the triggering input; no backpressure, and DRAIN holds off new tasks.
package stu_pkg;
  localparam int NUM_CORES = 4;
  typedef logic [1:0] core_id_t;
endpackage

module stu_spec_validator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int COUNT_WIDTH    = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           l2_spec_task_active_in,
  input  stu_pkg::core_id_t              master_core_id_in,
  input  stu_pkg::core_id_t              l2_spec_core_id_in,
  input  logic                           violation_in,
  input  logic                           spec_done_in,
  input  logic                           master_join_in,
  output logic [stu_pkg::NUM_CORES-1:0]  squash_out,
  output logic [stu_pkg::NUM_CORES-1:0]  commit_out,
  output logic                           result_valid_out,
  output logic [1:0]                     result_reason_out,
  output logic                           busy_out,
  output logic [COUNT_WIDTH-1:0]         commit_count_out,
  output logic [COUNT_WIDTH-1:0]         squash_count_out
);

  typedef enum logic [2:0] {IDLE, RUN, COMMIT, SQUASH, DRAIN} state_t;

  localparam logic [1:0]  RSN_COMMIT    = 2'b00;
  localparam logic [1:0]  RSN_VIOLATION = 2'b01;
  localparam logic [1:0]  RSN_TIMEOUT   = 2'b10;
  localparam logic [1:0]  RSN_ABORT     = 2'b11;
  localparam logic [15:0] TIMER_LAST    = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [stu_pkg::NUM_CORES-1:0] ONE = 1;

  state_t            state_q, state_d;
  stu_pkg::core_id_t spec_id_q, spec_id_d;
  stu_pkg::core_id_t master_q, master_d;
  logic [1:0]        reason_q, reason_d;
  logic [15:0]       timer_q, timer_d;
  logic              done_q, done_d;
  logic              join_q, join_d;
  logic [stu_pkg::NUM_CORES-1:0] target_vec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      spec_id_q <= '0;
      master_q  <= '0;
      reason_q  <= '0;
      timer_q   <= '0;
      done_q    <= 1'b0;
      join_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      spec_id_q <= spec_id_d;
      master_q  <= master_d;
      reason_q  <= reason_d;
      timer_q   <= timer_d;
      done_q    <= done_d;
      join_q    <= join_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    spec_id_d = spec_id_q;
    master_d  = master_q;
    reason_d  = reason_q;
    timer_d   = timer_q;
    done_d    = done_q;
    join_d    = join_q;
    case (state_q)
      IDLE: begin
        if (l2_spec_task_active_in) begin
          spec_id_d = l2_spec_core_id_in;
          master_d  = master_core_id_in;
          done_d    = 1'b0;
          join_d    = 1'b0;
          timer_d   = '0;
          // A task "speculating" on the master itself is meaningless; reject it outright.
          if (l2_spec_core_id_in == master_core_id_in) begin
            state_d  = SQUASH;
            reason_d = RSN_ABORT;
          end else begin
            state_d  = RUN;
          end
        end
      end
      RUN: begin
        timer_d = timer_q + 16'd1;
        if (spec_done_in)   done_d = 1'b1;
        if (master_join_in) join_d = 1'b1;
        if (violation_in) begin
          state_d  = SQUASH;
          reason_d = RSN_VIOLATION;
        end else if (!l2_spec_task_active_in) begin
          state_d  = SQUASH;
          reason_d = RSN_ABORT;
        end else if ((done_q || spec_done_in) && (join_q || master_join_in)) begin
          state_d  = COMMIT;
          reason_d = RSN_COMMIT;
        end else if (timer_q == TIMER_LAST) begin
          state_d  = SQUASH;
          reason_d = RSN_TIMEOUT;
        end
      end
      COMMIT:  state_d = DRAIN;
      SQUASH:  state_d = DRAIN;
      DRAIN: begin
        if (!l2_spec_task_active_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The master bit is masked so a master-id abort reports a decision without squashing the master.
  assign target_vec = (ONE << spec_id_q) & ~(ONE << master_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      commit_out        <= '0;
      squash_out        <= '0;
      result_valid_out  <= 1'b0;
      result_reason_out <= '0;
      commit_count_out  <= '0;
      squash_count_out  <= '0;
    end else begin
      commit_out       <= '0;
      squash_out       <= '0;
      result_valid_out <= 1'b0;
      if (state_q == COMMIT) begin
        commit_out        <= target_vec;
        result_valid_out  <= 1'b1;
        result_reason_out <= reason_q;
        if (commit_count_out != '1) commit_count_out <= commit_count_out + COUNT_WIDTH'(1);
      end else if (state_q == SQUASH) begin
        squash_out        <= target_vec;
        result_valid_out  <= 1'b1;
        result_reason_out <= reason_q;
        if (squash_count_out != '1) squash_count_out <= squash_count_out + COUNT_WIDTH'(1);
      end
    end
  end

  assign busy_out = (state_q != IDLE);

endmodule

// File: tb/tb_stu_spec_validator.sv
// Directed bench for stu_spec_validator; stimulus queues expected decisions, a negedge monitor checks them.
module tb_stu_spec_validator;

  logic       clk = 1'b0;
  logic       rst;
  logic       active;
  logic [1:0] master_id;
  logic [1:0] spec_id;
  logic       violation;
  logic       spec_done;
  logic       master_join;
  logic [3:0] squash_vec;
  logic [3:0] commit_vec;
  logic       result_valid;
  logic [1:0] result_reason;
  logic       busy;
  logic [1:0] commit_count;
  logic [1:0] squash_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    logic [3:0] cv;
    logic [3:0] sv;
    logic [1:0] rsn;
    logic [1:0] cc;
    logic [1:0] sc;
    int         cyc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [1:0] hold_reason = 2'b00;
  logic [1:0] cc_tab [5] = '{2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  stu_spec_validator #(.TIMEOUT_CYCLES(8), .COUNT_WIDTH(2)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .l2_spec_task_active_in (active),
    .master_core_id_in      (master_id),
    .l2_spec_core_id_in     (spec_id),
    .violation_in           (violation),
    .spec_done_in           (spec_done),
    .master_join_in         (master_join),
    .squash_out             (squash_vec),
    .commit_out             (commit_vec),
    .result_valid_out       (result_valid),
    .result_reason_out      (result_reason),
    .busy_out               (busy),
    .commit_count_out       (commit_count),
    .squash_count_out       (squash_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected decision appears lat cycles after the currently driven inputs are sampled.
  task automatic expect_dec(input logic [3:0] cv, input logic [3:0] sv, input logic [1:0] rsn,
                            input logic [1:0] cc, input logic [1:0] sc, input int lat);
    exp_t e;
    e.cv = cv; e.sv = sv; e.rsn = rsn; e.cc = cc; e.sc = sc; e.cyc = cyc + lat;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      hold_reason = 2'b00;
    end else begin
      chk("at_most_one_bit", 16'($countones({commit_vec, squash_vec}) <= 1), 16'd1);
      chk("master_bits", {14'd0, commit_vec[0], squash_vec[0]}, 16'd0);
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_decision: got commit %b squash %b reason %b, expected none (cycle %0d)",
                   commit_vec, squash_vec, result_reason, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("dec_cycle", 16'(cyc), 16'(mon_e.cyc));
          chk("commit_vec", {12'd0, commit_vec}, {12'd0, mon_e.cv});
          chk("squash_vec", {12'd0, squash_vec}, {12'd0, mon_e.sv});
          chk("reason", {14'd0, result_reason}, {14'd0, mon_e.rsn});
          chk("commit_count", {14'd0, commit_count}, {14'd0, mon_e.cc});
          chk("squash_count", {14'd0, squash_count}, {14'd0, mon_e.sc});
          hold_reason = mon_e.rsn;
        end
      end else begin
        chk("quiet_vectors", {8'd0, commit_vec, squash_vec}, 16'd0);
        chk("reason_hold", {14'd0, result_reason}, {14'd0, hold_reason});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; active = 1'b0; master_id = 2'd0; spec_id = 2'd0;
    violation = 1'b0; spec_done = 1'b0; master_join = 1'b0;
    tick(2);
    chk("rst_commit_vec", {12'd0, commit_vec}, 16'd0);
    chk("rst_squash_vec", {12'd0, squash_vec}, 16'd0);
    chk("rst_valid", {15'd0, result_valid}, 16'd0);
    chk("rst_reason", {14'd0, result_reason}, 16'd0);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_counts", {12'd0, commit_count, squash_count}, 16'd0);
    rst = 1'b1;
    tick();
    chk("idle_busy", {15'd0, busy}, 16'd0);

    // Commit on core 2; id change mid-RUN must be ignored.
    active = 1'b1; spec_id = 2'd2;
    tick();
    chk("run_busy", {15'd0, busy}, 16'd1);
    spec_done = 1'b1;
    tick();
    spec_done = 1'b0; spec_id = 2'd3;
    tick(4);
    master_join = 1'b1;
    expect_dec(4'b0100, 4'b0000, 2'b00, 2'd1, 2'd0, 2);
    tick();
    master_join = 1'b0;
    tick(4);
    active = 1'b0;
    tick(2);

    // Violation beats a completing join on the same cycle.
    active = 1'b1; spec_id = 2'd1;
    tick();
    master_join = 1'b1;
    tick();
    master_join = 1'b0; spec_done = 1'b1; violation = 1'b1;
    expect_dec(4'b0000, 4'b0010, 2'b01, 2'd1, 2'd1, 2);
    tick();
    spec_done = 1'b0; violation = 1'b0;
    tick(4);
    active = 1'b0;
    tick(2);

    // Timeout: RUN entry, 8 RUN cycles, then one register stage.
    active = 1'b1; spec_id = 2'd3;
    tick();
    expect_dec(4'b0000, 4'b1000, 2'b10, 2'd1, 2'd2, 9);
    tick(14);
    active = 1'b0;
    tick(2);

    // Abort by active dropping, then DRAIN ignores violation and pulses.
    active = 1'b1; spec_id = 2'd2;
    tick(2);
    active = 1'b0;
    expect_dec(4'b0000, 4'b0100, 2'b11, 2'd1, 2'd3, 2);
    tick();
    active = 1'b1;
    tick();
    chk("drain_busy", {15'd0, busy}, 16'd1);
    violation = 1'b1;
    tick();
    violation = 1'b0; spec_done = 1'b1; master_join = 1'b1;
    tick();
    spec_done = 1'b0; master_join = 1'b0; violation = 1'b1;
    tick();
    violation = 1'b0;
    tick(3);
    active = 1'b0;
    tick(2);

    // Spec id equal to master: abort with no core bit, squash counter saturates.
    active = 1'b1; spec_id = 2'd0;
    expect_dec(4'b0000, 4'b0000, 2'b11, 2'd1, 2'd3, 2);
    tick(4);
    active = 1'b0;
    tick(2);

    // Five back-to-back commits saturate the 2-bit commit counter.
    for (int k = 0; k < 5; k++) begin
      active = 1'b1; spec_id = 2'd1;
      tick();
      spec_done = 1'b1; master_join = 1'b1;
      expect_dec(4'b0010, 4'b0000, 2'b00, cc_tab[k], 2'd3, 2);
      tick();
      spec_done = 1'b0; master_join = 1'b0;
      tick(2);
      active = 1'b0;
      tick(2);
    end

    // Reset in the COMMIT entry cycle suppresses the pulse.
    active = 1'b1; spec_id = 2'd3;
    tick();
    spec_done = 1'b1; master_join = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("arst_busy", {15'd0, busy}, 16'd0);
    chk("arst_commit_vec", {12'd0, commit_vec}, 16'd0);
    chk("arst_counts", {12'd0, commit_count, squash_count}, 16'd0);
    spec_done = 1'b0; master_join = 1'b0; active = 1'b0;
    tick(2);
    rst = 1'b1;
    tick();
    active = 1'b1; spec_id = 2'd2;
    tick();
    spec_done = 1'b1; master_join = 1'b1;
    expect_dec(4'b0100, 4'b0000, 2'b00, 2'd1, 2'd0, 2);
    tick();
    spec_done = 1'b0; master_join = 1'b0;
    tick(3);
    active = 1'b0;
    tick(5);

    chk("pending_decisions", 16'(exp_q.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
